// File: rtl/or3_test_sequencer_pkg.sv
// Shared definitions for the OR3 exhaustive test sequencer.
// Contents:
//   DEFAULT_N_IN - default number of gate inputs (A, B, C).
//   CNT_W        - width of the settle counter, which holds at most SETTLE-1.
//   state_t      - 2-bit binary sequencer state encoding.
package or3_test_sequencer_pkg;

  localparam int DEFAULT_N_IN = 3;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/or3_test_sequencer_if.sv
// Control, status and gate-side signals of the OR3 test sequencer.
// Modports:
//   master - the side that requests sweeps and provides the gate output:
//            drives start, abort and y_in; observes every status signal.
//   slave  - the sequencer: receives start, abort and y_in; drives vec_out,
//            busy, done, pass, err_count, first_fail_vec and first_fail_valid.
interface or3_test_sequencer_if
  import or3_test_sequencer_pkg::*;
#(
  parameter int N_IN  = DEFAULT_N_IN,
  parameter int ERR_W = 4
);
  logic             start;
  logic             abort;
  logic             y_in;
  logic [N_IN-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, abort, y_in,
    input  vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, abort, y_in,
    output vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/or3_vec_counter.sv
// Test-vector register for the OR3 sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset.
//   clr       - load all zeros (takes priority over inc).
//   inc       - advance to the next vector.
//   vec       - current vector, MSB = A.
//   all_ones  - vec is the last vector of the sweep.
module or3_vec_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] vec,
  output logic         all_ones
);

  logic [W-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (clr) begin
      vec_d = '0;
    end else if (inc) begin
      vec_d = vec_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec      = vec_q;
  assign all_ones = &vec_q;

endmodule

// File: rtl/or3_test_sequencer.sv
// Exhaustive built-in test controller for a 3-input OR gate.
// A start pulse sweeps the gate inputs 0..2^N_IN-1; each vector is held for
// SETTLE cycles, then Y is sampled and compared with the reduction OR.
// Ports:
//   clk  - system clock, rising edge.
//   rst  - synchronous active-high reset.
//   bus  - slave modport: start/abort requests, y_in from the gate, vec_out
//          to the gate, busy/done/pass status, err_count (saturating) and
//          the first failing vector with its valid flag.
module or3_test_sequencer
  import or3_test_sequencer_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  or3_test_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffvalid_q, ffvalid_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              vec_clr, vec_inc, vec_all_ones;
  logic [N_IN-1:0]   vec;
  logic              mismatch;

  or3_vec_counter #(.W(N_IN)) u_vec (
    .clk      (clk),
    .rst      (rst),
    .clr      (vec_clr),
    .inc      (vec_inc),
    .vec      (vec),
    .all_ones (vec_all_ones)
  );

  assign mismatch = (bus.y_in != (|vec));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    vec_clr   = 1'b0;
    vec_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort in the same cycle suppresses the start request
        if (bus.start && !bus.abort) begin
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          vec_clr   = 1'b1;
          cnt_d     = CNT_RELOAD;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SAMPLE: begin
        // the sample is recorded even when abort arrives in this cycle
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!ffvalid_q) begin
            ffv_d     = vec;
            ffvalid_d = 1'b1;
          end
        end
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (vec_all_ones) begin
          // pass reflects the count including this final sample
          pass_d  = (err_d == '0);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          vec_inc = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // the vector is only presented to the gate while a sweep is running
  assign bus.vec_out          = busy_q ? vec : '0;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_or3_test_sequencer.sv
// Directed bench for or3_test_sequencer with default parameters.
// y_mode selects the gate model feeding y_in: 0 = OR, 1 = stuck 0,
// 2 = stuck 1, 3 = AND.
module tb_or3_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   y_mode = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  or3_test_sequencer_if #(.N_IN(3), .ERR_W(4)) bus ();

  assign bus.y_in = (y_mode == 0) ? (|bus.vec_out) :
                    (y_mode == 1) ? 1'b0 :
                    (y_mode == 2) ? 1'b1 : (&bus.vec_out);

  or3_test_sequencer #(.N_IN(3), .SETTLE(1), .ERR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are then observed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},    32'(bus.busy), 0);
    check_eq({tag, "_done"},    32'(bus.done), 0);
    check_eq({tag, "_pass"},    32'(bus.pass), 0);
    check_eq({tag, "_vec"},     32'(bus.vec_out), 0);
    check_eq({tag, "_err"},     32'(bus.err_count), 0);
    check_eq({tag, "_ffv"},     32'(bus.first_fail_vec), 0);
    check_eq({tag, "_ffvalid"}, 32'(bus.first_fail_valid), 0);
  endtask

  // full sweep with timing checks: 16 busy cycles, vec held 2 cycles each,
  // done in cycle 17, results holding afterwards
  task automatic run_sweep(input string tag, input int mode, input int e_err,
                           input int e_ffv, input int e_ffvalid, input int e_pass);
    int bad_busy = 0;
    int bad_vec  = 0;
    int bad_done = 0;
    y_mode = mode;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus.busy !== 1'b1) bad_busy++;
      if (32'(bus.vec_out) != 32'(k / 2)) bad_vec++;
      if (bus.done !== 1'b0) bad_done++;
      tick();
    end
    check_eq({tag, "_busy_cycles_bad"}, bad_busy, 0);
    check_eq({tag, "_vec_order_bad"},   bad_vec, 0);
    check_eq({tag, "_early_done"},      bad_done, 0);
    check_eq({tag, "_done17"},          32'(bus.done), 1);
    check_eq({tag, "_busy17"},          32'(bus.busy), 0);
    check_eq({tag, "_vec17"},           32'(bus.vec_out), 0);
    check_eq({tag, "_pass"},            32'(bus.pass), e_pass);
    check_eq({tag, "_err"},             32'(bus.err_count), e_err);
    check_eq({tag, "_ffv"},             32'(bus.first_fail_vec), e_ffv);
    check_eq({tag, "_ffvalid"},         32'(bus.first_fail_valid), e_ffvalid);
    tick();
    check_eq({tag, "_done_pulse"},      32'(bus.done), 0);
    check_eq({tag, "_pass_hold"},       32'(bus.pass), e_pass);
    check_eq({tag, "_err_hold"},        32'(bus.err_count), e_err);
    $display("sweep %s: mode=%0d err=%0d ffv=%0d ffvalid=%0d pass=%0d", tag, mode,
             bus.err_count, bus.first_fail_vec, bus.first_fail_valid, bus.pass);
  endtask

  initial begin
    int done_seen;
    int reached;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // sweeps against the four gate models
    run_sweep("good_or", 0, 0, 0, 0, 1);
    run_sweep("stuck0",  1, 7, 1, 1, 0);
    run_sweep("stuck1",  2, 1, 0, 1, 0);
    run_sweep("and_gate", 3, 6, 1, 1, 0);

    // start together with abort in IDLE is ignored
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("start_abort_busy", 32'(bus.busy), 0);
    check_eq("start_abort_pass_kept", 32'(bus.pass), 0);
    check_eq("start_abort_err_kept", 32'(bus.err_count), 6);
    $display("start+abort in idle: busy=%0d", bus.busy);

    // abort during SAMPLE of 011 with Y stuck at 0; mid-sweep start ignored
    y_mode = 1;
    bus.start = 1'b1;
    tick();                       // cycle 1: SETTLE vec 0
    bus.start = 1'b0;
    tick();
    tick();                       // cycle 3: SETTLE vec 1
    bus.start = 1'b1;
    tick();                       // cycle 4: SAMPLE vec 1
    bus.start = 1'b0;
    check_eq("midstart_vec", 32'(bus.vec_out), 1);
    check_eq("midstart_busy", 32'(bus.busy), 1);
    tick();
    tick();
    tick();
    tick();                       // cycle 8: SAMPLE vec 3
    check_eq("abort_at_vec", 32'(bus.vec_out), 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_vec", 32'(bus.vec_out), 0);
    check_eq("abort_done", 32'(bus.done), 0);
    check_eq("abort_pass", 32'(bus.pass), 0);
    check_eq("abort_err_partial", 32'(bus.err_count), 3);
    check_eq("abort_ffv", 32'(bus.first_fail_vec), 1);
    check_eq("abort_ffvalid", 32'(bus.first_fail_valid), 1);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      tick();
    end
    check_eq("abort_no_done", done_seen, 0);
    $display("abort at 011: err=%0d ffv=%0d", bus.err_count, bus.first_fail_vec);
    run_sweep("after_abort", 0, 0, 0, 0, 1);

    // reset mid-sweep at vec 101 with Y stuck at 0
    y_mode = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    reached = 0;
    for (int i = 0; i < 30 && reached == 0; i++) begin
      if (bus.vec_out == 3'b101) reached = 1;
      else tick();
    end
    check_eq("reach_vec101", reached, 1);
    check_eq("pre_reset_err", 32'(bus.err_count), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midreset");
    tick();
    check_all_zero("midreset_idle");
    $display("reset at 101: busy=%0d err=%0d", bus.busy, bus.err_count);
    run_sweep("after_reset", 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or3_test_sequencer.md
Name: or3_test_sequencer

Overview:
Built-in exhaustive test controller for the 3-input dataflow OR gate. On a start pulse it steps the gate inputs through every combination from 000 to 111, waits a settle interval and samples Y. It compares Y against the expected OR, counts mismatches and records the first failing vector. It sits beside the gate instance: it drives A/B/C and reads Y, replacing the hand-timed stimulus used in bench-only checking.

Parameters:
N_IN, 3, number of gate inputs; sweep length is 2^N_IN vectors.
SETTLE, 1, clock cycles between driving a vector and sampling Y; legal range 1..15.
ERR_W, 4, width of the mismatch counter; it saturates at 2^ERR_W-1.

Ports:
clk  input  1  single system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
abort  input  1  terminates a sweep in progress.
vec_out  output  N_IN  gate inputs; MSB=A, then B, LSB=C.
y_in  input  1  gate output Y.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes normally.
pass  output  1  1 when the last completed sweep had zero mismatches.
err_count  output  ERR_W  mismatches in the current or last sweep.
first_fail_vec  output  N_IN  first vector whose Y mismatched.
first_fail_valid  output  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset (rst=1 at an edge, including mid-sweep): state=IDLE; all outputs 0 on the next cycle.
- States: IDLE, SETTLE, SAMPLE, DONE. Encoding is binary, 2 bits.
- IDLE:
  - vec_out=0, busy=0.
  - On start=1: clear err_count, first_fail_vec, first_fail_valid and pass; vec=0; settle counter=SETTLE-1; go to SETTLE.
- SETTLE:
  - busy=1; vec_out=vec.
  - Counter decrements each cycle. When it reaches 0, go to SAMPLE.
  - Each vector spends exactly SETTLE cycles in SETTLE.
- SAMPLE:
  - busy=1; vec_out=vec.
  - Expected value is the reduction OR of vec. Mismatch = y_in != expected.
  - On a mismatch: err_count increments, saturating at max. If first_fail_valid=0, capture vec into first_fail_vec and set first_fail_valid=1.
  - If vec is all ones, go to DONE. Otherwise vec increments, the counter reloads to SETTLE-1, and the state returns to SETTLE.
- DONE:
  - One cycle: done=1, busy=0, pass=(err_count==0 after the final sample).
  - vec_out returns to 0. Next state is IDLE.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - With defaults, busy is high for 16 cycles, starting the cycle after start is sampled.
  - done is high in the 17th cycle after the start edge.
- Results (err_count, first_fail_*, pass) hold until the next accepted start or reset.
- start while busy: ignored, no effect.
- start and abort in the same IDLE cycle: abort wins; start is ignored.
- abort in SETTLE or SAMPLE: next cycle is IDLE with busy=0, vec_out=0, no done pulse and pass=0. err_count and first_fail_* keep their partial values. A mismatch sampled in the abort cycle is still recorded.
- abort in DONE or IDLE: no effect.
- Arithmetic: vec is an N_IN-bit up-counter; it never wraps during a sweep, because the all-ones test ends the sweep first.

Decomposition:
- Shared include header: state codes (ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE) and the default N_IN.
- One natural sub-module, or3_vec_counter: vector register with clear, increment and an all-ones flag.
- The FSM, settle counter and result registers stay in the top module.

Test Plan:
1. y_in wired to a real 3-input OR of vec_out; pulse start -> busy for 16 cycles, done at cycle 17, pass=1, err_count=0, first_fail_valid=0; vec_out visits 000..111 in order, each held 2 cycles.
2. y_in tied to 0 -> err_count=7, first_fail_vec=001, first_fail_valid=1, pass=0.
3. y_in tied to 1 -> err_count=1, first_fail_vec=000, pass=0.
4. y_in from a 3-input AND -> err_count=6 (vectors 001..110), first_fail_vec=001, pass=0.
5. Assert abort while vec_out=011 -> busy=0 and vec_out=000 next cycle, no done. A start mid-sweep is ignored. A fresh start with a good OR gate then completes with pass=1 and err_count=0.
6. Run with y_in stuck at 0, then assert rst at vec_out=101 -> next cycle all outputs 0, state IDLE. A following start runs a normal full sweep.
